// File: rtl/melody_seq.sv
// Note-memory driven melody sequencer: fetches 16-bit note words, plays each
// for its beat count against an external beat counter, with pause/stop/loop.
module melody_seq #(
  parameter int ADDR_W = 8,
  parameter int TONE_W = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  input  logic [27:0]       tempo,
  output logic [ADDR_W-1:0] note_addr,
  output logic              note_rd,
  input  logic [15:0]       note_rdata,
  output logic [27:0]       beat_cnt_parameter,
  output logic              beat_en,
  input  logic              beat_finish,
  output logic [TONE_W-1:0] tone_div,
  output logic              tone_en,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_PLAY  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [3:0]          r_beats_left;
  logic [ADDR_W-1:0]   r_note_addr;
  logic                r_note_rd;
  logic [27:0]         r_beat_cnt_parameter;
  logic                r_beat_en;
  logic [TONE_W-1:0]   r_tone_div;
  logic                r_tone_en;
  logic                r_busy;
  logic                r_done;

  logic                w_beat_counted;
  logic [ADDR_W-1:0]   w_next_ptr;
  logic [3:0]          w_note_beats;
  logic [TONE_W-1:0]   w_note_tone;

  // A beat only counts while the counter is actually enabled, so a finish
  // flag seen during pause cannot be counted twice.
  assign w_beat_counted = beat_finish && r_beat_en;
  assign w_next_ptr     = r_ptr + ADDR_W'(1);
  assign w_note_beats   = note_rdata[15:12];
  assign w_note_tone    = TONE_W'(note_rdata[11:0]);

  // Sequencer state machine; every output is a register updated here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state              <= S_IDLE;
      r_ptr                <= '0;
      r_beats_left         <= 4'd0;
      r_note_addr          <= '0;
      r_note_rd            <= 1'b0;
      r_beat_cnt_parameter <= 28'd0;
      r_beat_en            <= 1'b0;
      r_tone_div           <= '0;
      r_tone_en            <= 1'b0;
      r_busy               <= 1'b0;
      r_done               <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_note_rd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_ptr       <= '0;
            r_note_addr <= '0;
            r_note_rd   <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_FETCH;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FETCH: begin
          if (stop) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (stop) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_note_beats == 4'd0) begin
            if (loop) begin
              r_ptr       <= '0;
              r_note_addr <= '0;
              r_note_rd   <= 1'b1;
              r_state     <= S_FETCH;
            end else begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_beats_left         <= w_note_beats;
            r_beat_cnt_parameter <= tempo;
            r_tone_div           <= w_note_tone;
            r_beat_en            <= 1'b1;
            r_tone_en            <= (w_note_tone != '0) && !pause;
            r_state              <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (stop) begin
            r_tone_en <= 1'b0;
            // If the beat completes on the stop cycle the counter is already back at 0.
            if (w_beat_counted) begin
              r_beat_en <= 1'b0;
              r_busy    <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_beat_en <= 1'b1;
              r_state   <= S_DRAIN;
            end
          end else if (w_beat_counted && (r_beats_left == 4'd1)) begin
            r_ptr        <= w_next_ptr;
            r_note_addr  <= w_next_ptr;
            r_note_rd    <= 1'b1;
            r_beats_left <= 4'd0;
            r_beat_en    <= 1'b0;
            r_tone_en    <= 1'b0;
            r_state      <= S_FETCH;
          end else begin
            if (w_beat_counted) begin
              r_beats_left <= r_beats_left - 4'd1;
            end else begin
              r_beats_left <= r_beats_left;
            end
            r_beat_en <= !pause;
            r_tone_en <= (r_tone_div != '0) && !pause;
            r_state   <= S_PLAY;
          end
        end
        S_DRAIN: begin
          r_tone_en <= 1'b0;
          if (beat_finish) begin
            r_beat_en <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_beat_en <= 1'b1;
            r_state   <= S_DRAIN;
          end
        end
        default: begin
          r_beat_en <= 1'b0;
          r_tone_en <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign note_addr          = r_note_addr;
  assign note_rd            = r_note_rd;
  assign beat_cnt_parameter = r_beat_cnt_parameter;
  assign beat_en            = r_beat_en;
  assign tone_div           = r_tone_div;
  assign tone_en            = r_tone_en;
  assign busy               = r_busy;
  assign done               = r_done;

endmodule

// File: tb/tb_melody_seq.sv
// Directed bench for melody_seq with a behavioural note memory and beat counter.
module tb_melody_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic        loop_s = 1'b0;
  logic [27:0] tempo = 28'd9;
  logic [7:0]  note_addr;
  logic        note_rd;
  logic [15:0] note_rdata;
  logic [27:0] beat_cnt_parameter;
  logic        beat_en;
  logic        beat_finish;
  logic [11:0] tone_div;
  logic        tone_en;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int n_beat, n_tone, n_done, done_at;
  logic [7:0]  prev_addr;
  logic        wrapped;
  logic [27:0] cnt;
  logic [15:0] mem [0:255];

  melody_seq #(.ADDR_W(8), .TONE_W(12)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .pause(pause),
    .loop(loop_s), .tempo(tempo), .note_addr(note_addr), .note_rd(note_rd),
    .note_rdata(note_rdata), .beat_cnt_parameter(beat_cnt_parameter),
    .beat_en(beat_en), .beat_finish(beat_finish), .tone_div(tone_div),
    .tone_en(tone_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // External beat counter: wraps to 0 at the terminal count, frozen when disabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt <= 28'd0;
    else if (beat_en) cnt <= (cnt == beat_cnt_parameter) ? 28'd0 : cnt + 28'd1;
  end
  assign beat_finish = (cnt == beat_cnt_parameter);

  // Note memory with one-cycle read latency.
  always_ff @(posedge clk) begin
    if (note_rd) note_rdata <= mem[note_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (beat_en) n_beat++;
    if (tone_en) n_tone++;
    if (done) n_done++;
  endtask

  task automatic clr_stats();
    n_beat = 0; n_tone = 0; n_done = 0; done_at = 0;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int k = 0;
    while (busy && k < lim) begin
      step();
      k++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    mem[0] = 16'h3100; mem[1] = 16'h2000; mem[2] = 16'h0000;

    #12;
    chk("rst_note_rd", {31'd0, note_rd}, 32'd0);
    chk("rst_beat_en", {31'd0, beat_en}, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_tone", {19'd0, tone_div, tone_en}, 32'd0);
    rstn = 1'b1;
    step(); step();

    // Basic song, no loop
    clr_stats();
    kick();
    chk("t1_fetch_rd", {31'd0, note_rd}, 32'd1);
    chk("t1_fetch_addr", {24'd0, note_addr}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    for (int i = 2; i <= 70; i++) begin
      step();
      if (i == 3) begin
        chk("t1_tone_div", {20'd0, tone_div}, 32'h100);
        chk("t1_tone_en", {31'd0, tone_en}, 32'd1);
        chk("t1_tempo", {4'd0, beat_cnt_parameter}, 32'd9);
      end
      if (i == 35) chk("t1_rest", {30'd0, beat_en, tone_en}, 32'd2);
      if (done && done_at == 0) done_at = i;
    end
    chk("t1_done_at", done_at, 32'd57);
    chk("t1_beat_cycles", n_beat, 32'd50);
    chk("t1_tone_cycles", n_tone, 32'd30);
    chk("t1_done_count", n_done, 32'd1);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // Looping song, then stop in PLAY
    loop_s = 1'b1;
    clr_stats();
    kick();
    for (int i = 2; i <= 70; i++) begin
      step();
      if (i == 57) chk("t2_refetch", {23'd0, note_rd, note_addr}, 32'h100);
      if (i == 59) chk("t2_replay_tone", {20'd0, tone_div}, 32'h100);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    loop_s = 1'b0;
    chk("t2_drain", {30'd0, beat_en, tone_en}, 32'd2);
    wait_idle("t2_idle", 40);
    chk("t2_no_done", n_done, 32'd0);

    // Pause starting on the terminal-count cycle of the first beat
    clr_stats();
    kick();
    for (int i = 2; i <= 70; i++) begin
      step();
      if (i == 11) pause = 1'b1;
      if (i == 18) pause = 1'b0;
      if (i == 12) chk("t3_paused", {30'd0, beat_en, tone_en}, 32'd0);
      if (i == 19) chk("t3_resumed", {30'd0, beat_en, tone_en}, 32'd3);
      if (done && done_at == 0) done_at = i;
    end
    chk("t3_done_at", done_at, 32'd64);
    chk("t3_beat_cycles", n_beat, 32'd50);

    // Stop mid-note: drain to terminal count, pause ignored in drain
    clr_stats();
    kick();
    for (int i = 2; i <= 7; i++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t4_drain", {29'd0, busy, beat_en, tone_en}, 32'd6);
    pause = 1'b1;
    step(); step();
    chk("t4_drain_pause", {31'd0, beat_en}, 32'd1);
    pause = 1'b0;
    step(); step();
    chk("t4_still_busy", {31'd0, busy}, 32'd1);
    step();
    chk("t4_idle", {30'd0, busy, beat_en}, 32'd0);
    chk("t4_counter", {4'd0, cnt}, 32'd0);
    chk("t4_no_done", n_done, 32'd0);
    kick();
    chk("t4_restart", {23'd0, note_rd, note_addr}, 32'h100);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t4_stop_fetch", {30'd0, busy, note_rd}, 32'd0);
    step();

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("t5_start_stop", {30'd0, busy, note_rd}, 32'd0);

    // Asynchronous reset mid-PLAY
    kick();
    repeat (10) step();
    #2 rstn = 1'b0;
    #1;
    chk("t6_async_en", {29'd0, beat_en, tone_en, busy}, 32'd0);
    chk("t6_async_vals", {8'd0, tone_div, note_addr, 3'd0, note_rd}, 32'd0);
    chk("t6_async_tempo", {4'd0, beat_cnt_parameter}, 32'd0);
    #2 rstn = 1'b1;
    repeat (3) step();
    chk("t6_post_release", {30'd0, busy, beat_en}, 32'd0);

    // Pointer wrap with one-cycle beats
    for (int a = 0; a < 256; a++) mem[a] = 16'h1001;
    tempo = 28'd0;
    clr_stats();
    kick();
    prev_addr = note_addr;
    wrapped = 1'b0;
    for (int i = 0; i < 1000 && !wrapped; i++) begin
      step();
      if (note_rd) begin
        if (prev_addr == 8'd255) begin
          chk("t7_wrap_addr", {24'd0, note_addr}, 32'd0);
          chk("t7_notes_played", n_beat, 32'd256);
          wrapped = 1'b1;
        end else begin
          prev_addr = note_addr;
        end
      end
    end
    chk("t7_wrapped", {31'd0, wrapped}, 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle("t7_idle", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
